// File: rtl/fsm_i2c_master.sv
// Single-byte I2C master: START, address+R/W, address ACK wait, one data byte, STOP.
// Every SCL/SDA change lands on a half-period tick; SDA is open-drain.
module fsm_i2c_master #(
    parameter int unsigned HALF_PERIOD = 1,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] address,
    input  logic       rw,
    input  logic [7:0] idata,
    input  logic       ACK_ADDR,
    input  logic       sda_in,
    output logic       shift_en,
    output logic [7:0] odata,
    inout  wire        i2c_sda,
    output logic       i2c_scl
);

    localparam int unsigned TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int unsigned AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMR_MAX = TW'(HALF_PERIOD - 1);
    localparam logic [AW-1:0] ACK_MAX = AW'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle, StStart, StAddr, StAddrAck, StWdata, StWack, StRdata, StRnack, StStop
    } state_e;

    state_e        state_q, state_d;
    logic          scl_q, scl_d;
    logic          sda_oe_q, sda_oe_d;
    logic          phase_q, phase_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [AW-1:0] ack_cnt_q, ack_cnt_d;
    logic [6:0]    addr_q, addr_d;
    logic          rw_q, rw_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    odata_q, odata_d;
    logic          shift_en_q, shift_en_d;

    logic          tick;
    logic [7:0]    tx_byte;
    logic          nxt_bit;

    assign tick    = (tmr_q == TMR_MAX);
    assign tx_byte = (state_q == StAddr) ? {addr_q, rw_q} : wdata_q;
    // Bit sent in the low phase that follows the current one.
    assign nxt_bit = tx_byte[3'd6 - bit_cnt_q];

    always_comb begin
        state_d    = state_q;
        scl_d      = scl_q;
        sda_oe_d   = sda_oe_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        tmr_d      = tick ? '0 : tmr_q + 1'b1;
        ack_cnt_d  = '0;
        addr_d     = addr_q;
        rw_d       = rw_q;
        wdata_d    = wdata_q;
        shreg_d    = shreg_q;
        odata_d    = odata_q;
        shift_en_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                tmr_d    = '0;
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
                phase_d  = 1'b0;
                if (start) begin
                    addr_d   = address;
                    rw_d     = rw;
                    wdata_d  = idata;
                    sda_oe_d = 1'b1;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    scl_d     = 1'b0;
                    sda_oe_d  = ~addr_q[6];
                    phase_d   = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = StAddr;
                end
            end
            StAddr, StWdata: begin
                if (tick) begin
                    if (!phase_q) begin
                        scl_d   = 1'b1;
                        phase_d = 1'b1;
                    end else if (bit_cnt_q == 3'd7) begin
                        scl_d    = 1'b0;
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                        state_d  = (state_q == StAddr) ? StAddrAck : StWack;
                    end else begin
                        scl_d     = 1'b0;
                        sda_oe_d  = ~nxt_bit;
                        phase_d   = 1'b0;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            StAddrAck: begin
                if (!phase_q) begin
                    // Hold SCL low until the slave acks, then give it one high pulse.
                    if (ACK_ADDR) begin
                        if (tick) begin
                            scl_d   = 1'b1;
                            phase_d = 1'b1;
                        end
                    end else if (ack_cnt_q == ACK_MAX) begin
                        sda_oe_d = 1'b1;
                        tmr_d    = '0;
                        state_d  = StStop;
                    end else begin
                        ack_cnt_d = ack_cnt_q + 1'b1;
                    end
                end else if (tick) begin
                    scl_d     = 1'b0;
                    phase_d   = 1'b0;
                    bit_cnt_d = '0;
                    if (rw_q) begin
                        sda_oe_d = 1'b0;
                        state_d  = StRdata;
                    end else begin
                        sda_oe_d = ~wdata_q[7];
                        state_d  = StWdata;
                    end
                end
            end
            StRdata: begin
                if (tick) begin
                    if (!phase_q) begin
                        scl_d      = 1'b1;
                        phase_d    = 1'b1;
                        shreg_d    = {shreg_q[6:0], sda_in};
                        shift_en_d = 1'b1;
                        if (bit_cnt_q == 3'd7) odata_d = {shreg_q[6:0], sda_in};
                    end else begin
                        scl_d   = 1'b0;
                        phase_d = 1'b0;
                        if (bit_cnt_q == 3'd7) state_d = StRnack;
                        else bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            StWack, StRnack: begin
                if (tick) begin
                    if (!phase_q) begin
                        scl_d   = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        scl_d    = 1'b0;
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b0;
                        state_d  = StStop;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (!phase_q) begin
                        scl_d   = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q    <= StIdle;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            phase_q    <= 1'b0;
            bit_cnt_q  <= '0;
            tmr_q      <= '0;
            ack_cnt_q  <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wdata_q    <= '0;
            shreg_q    <= '0;
            odata_q    <= '0;
            shift_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            tmr_q      <= tmr_d;
            ack_cnt_q  <= ack_cnt_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wdata_q    <= wdata_d;
            shreg_q    <= shreg_d;
            odata_q    <= odata_d;
            shift_en_q <= shift_en_d;
        end
    end

    assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
    assign i2c_scl  = scl_q;
    assign shift_en = shift_en_q;
    assign odata    = odata_q;

endmodule

// File: tb/tb_fsm_i2c_master.sv
// Directed bench for fsm_i2c_master: a passive bus monitor decodes START/STOP and SCL-rise bits,
// and the linear stimulus checks each transaction against hand-computed bit streams.
module tb_fsm_i2c_master;

    localparam int unsigned HP = 2;
    localparam int unsigned TO = 20;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [6:0] address;
    logic       rw;
    logic [7:0] idata;
    logic       ACK_ADDR;
    logic       sda_in;
    logic       shift_en;
    logic [7:0] odata;
    logic       i2c_scl;
    wire        i2c_sda;

    pullup (i2c_sda);

    fsm_i2c_master #(.HALF_PERIOD(HP), .ACK_TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .address  (address),
        .rw       (rw),
        .idata    (idata),
        .ACK_ADDR (ACK_ADDR),
        .sda_in   (sda_in),
        .shift_en (shift_en),
        .odata    (odata),
        .i2c_sda  (i2c_sda),
        .i2c_scl  (i2c_scl)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int           cyc = 0, starts = 0, stops = 0, nbits = 0, shifts = 0, fall_cyc = 0;
    logic [127:0] bits = '0;
    int           rise_at [256];
    logic         prev_scl = 1'b1, prev_sda = 1'b1;
    logic [7:0]   rd_pat = 8'hA5;

    // Slave read data: next MSB-first bit, advanced by each observed shift_en pulse.
    assign sda_in = rd_pat[~shifts[2:0]];

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        prev_scl <= i2c_scl;
        prev_sda <= i2c_sda;
        if (!reset_n) begin
            if (prev_scl && i2c_scl && prev_sda && !i2c_sda) starts <= starts + 1;
            if (prev_scl && i2c_scl && !prev_sda && i2c_sda) stops <= stops + 1;
            if (!prev_scl && i2c_scl) begin
                bits               <= {bits[126:0], i2c_sda};
                rise_at[nbits & 255] <= cyc;
                nbits              <= nbits + 1;
            end
            if (!prev_scl && !i2c_scl && prev_sda && !i2c_sda) fall_cyc <= cyc;
            if (shift_en) shifts <= shifts + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d);
        @(negedge clk);
        address = a;
        rw      = r;
        idata   = d;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_stops(input int target, input string tag);
        int n = 0;
        while (stops < target && n < 500) begin
            @(posedge clk);
            n++;
        end
        check(tag, 64'(stops >= target), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s0, p0, b0, sh0, n;
        reset_n  = 1'b1;
        start    = 1'b0;
        address  = '0;
        rw       = 1'b0;
        idata    = '0;
        ACK_ADDR = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_scl", 64'(i2c_scl), 64'd1);
        check("reset_sda", 64'(i2c_sda), 64'd1);
        check("reset_shift_en", 64'(shift_en), 64'd0);
        check("reset_odata", 64'(odata), 64'h00);
        reset_n = 1'b0;

        // Write 0x55 to 0x55.
        s0 = starts; p0 = stops; b0 = nbits;
        run_txn(7'h55, 1'b0, 8'h55);
        wait_stops(p0 + 1, "write_stop");
        check("write_starts", 64'(starts - s0), 64'd1);
        check("write_nbits", 64'(nbits - b0), 64'd19);
        check("write_bits", 64'(bits[18:0]), 64'({8'hAA, 1'b1, 8'h55, 1'b1, 1'b0}));
        check("write_idle_scl", 64'(i2c_scl), 64'd1);
        check("write_idle_sda", 64'(i2c_sda), 64'd1);
        check("write_odata", 64'(odata), 64'h00);

        // Read 0xA5 from 0x3C.
        s0 = starts; p0 = stops; b0 = nbits; sh0 = shifts;
        run_txn(7'h3C, 1'b1, 8'h00);
        wait_stops(p0 + 1, "read_stop");
        check("read_starts", 64'(starts - s0), 64'd1);
        check("read_shifts", 64'(shifts - sh0), 64'd8);
        check("read_odata", 64'(odata), 64'hA5);
        check("read_bits", 64'(bits[18:0]), 64'({8'h79, 1'b1, 8'hFF, 1'b1, 1'b0}));

        // Address NACK: timeout abort, no data phase.
        ACK_ADDR = 1'b0;
        s0 = starts; p0 = stops; b0 = nbits; sh0 = shifts;
        run_txn(7'h2A, 1'b0, 8'hFF);
        wait_stops(p0 + 1, "nack_stop");
        ACK_ADDR = 1'b1;
        check("nack_nbits", 64'(nbits - b0), 64'd9);
        check("nack_bits", 64'(bits[8:0]), 64'({8'h54, 1'b0}));
        check("nack_timeout", 64'(fall_cyc - rise_at[(b0 + 7) & 255]), 64'(TO + HP));
        check("nack_shifts", 64'(shifts - sh0), 64'd0);
        check("nack_odata", 64'(odata), 64'hA5);

        // Second start mid-address is ignored.
        s0 = starts; p0 = stops; b0 = nbits;
        run_txn(7'h12, 1'b0, 8'hC3);
        repeat (6) @(negedge clk);
        run_txn(7'h7F, 1'b1, 8'h00);
        wait_stops(p0 + 1, "busy_stop");
        check("busy_bits", 64'(bits[18:0]), 64'({7'h12, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0}));
        check("busy_nbits", 64'(nbits - b0), 64'd19);
        check("busy_odata", 64'(odata), 64'hA5);
        repeat (50) @(negedge clk);
        check("busy_one_txn", 64'(starts - s0), 64'd1);

        // start coincident with reset: reset wins.
        s0 = starts;
        @(negedge clk);
        reset_n = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_start_none", 64'(starts - s0), 64'd0);
        check("rst_start_scl", 64'(i2c_scl), 64'd1);

        // Reset during the read data phase.
        sh0 = shifts;
        run_txn(7'h3C, 1'b1, 8'h00);
        n = 0;
        while (shifts - sh0 < 3 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("mid_read_reached", 64'(shifts - sh0 >= 3), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_scl", 64'(i2c_scl), 64'd1);
        check("mid_rst_sda", 64'(i2c_sda), 64'd1);
        check("mid_rst_shift_en", 64'(shift_en), 64'd0);
        check("mid_rst_odata", 64'(odata), 64'h00);
        reset_n = 1'b0;
        p0 = stops; b0 = nbits;
        repeat (20) @(negedge clk);
        check("mid_rst_quiet_bits", 64'(nbits - b0), 64'd0);
        check("mid_rst_no_stop", 64'(stops - p0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
